// File: rtl/sample_responder_pkg.sv
// Shared constants for the Avalon sample-store responder: word width, pending
// counter width, stall LFSR taps and the default out-of-range read pattern.
package sample_responder_pkg;

    localparam int          WORD_W           = 32;
    localparam int          PEND_W           = 4;
    // Fibonacci taps 16,14,13,11 expressed as a mask over state[15:0]
    localparam logic [15:0] LFSR_TAPS        = 16'hB400;
    localparam logic [31:0] DEFAULT_OOR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/avalon_sample_responder_lfsr16.sv
// 16-bit Fibonacci LFSR that shifts every cycle; used by the responder to
// inject pseudo-random waitrequest stalls.
module lfsr16
    import sample_responder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= seed;
        end else begin
            state <= {state[14:0], ^(state & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/avalon_sample_responder.sv
// Avalon-MM sample store: pipelined in-order reads with fixed latency, single-beat
// writes, bounded outstanding reads. Macro AVALON_SAMPLE_RESPONDER_STALL_EN adds LFSR stalls.
module avalon_sample_responder
    import sample_responder_pkg::*;
#(
    parameter int                ADDR_W      = 24,
    parameter int                DEPTH       = 1024,
    parameter int                LATENCY     = 3,
    parameter int                MAX_PENDING = 4,
    parameter logic [WORD_W-1:0] OOR_DATA    = DEFAULT_OOR_DATA,
    parameter logic [15:0]       LFSR_SEED   = 16'hACE1
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [WORD_W-1:0] writedata,
    output logic              waitrequest,
    output logic [WORD_W-1:0] readdata,
    output logic              readdatavalid,
    output logic [PEND_W-1:0] pending,
    output logic              err
);

    localparam int IDX_W  = ADDR_W - 2;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IDX_W-1:0]  idx;
    logic [MEM_AW-1:0] mem_idx;
    logic              in_range;
    logic              stall;
    logic              rd_accept;
    logic              wr_accept;
    logic              unused_addr;

    assign idx         = address[ADDR_W-1:2];
    assign mem_idx     = idx[MEM_AW-1:0];
    assign in_range    = {{(32-IDX_W){1'b0}}, idx} < 32'(DEPTH);
    assign unused_addr = ^address[1:0];

`ifdef AVALON_SAMPLE_RESPONDER_STALL_EN
    logic [15:0] lfsr_state;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (LFSR_SEED),
        .state (lfsr_state)
    );

    assign stall = (lfsr_state[1:0] == 2'b00);
`else
    logic unused_seed;
    assign unused_seed = ^LFSR_SEED;
    assign stall       = 1'b0;
`endif

    // Conservative throttle: a response retiring this cycle does not free a slot early
    assign waitrequest = (pending == PEND_W'(MAX_PENDING)) || stall;
    assign rd_accept   = read && !waitrequest;
    assign wr_accept   = write && !read && !waitrequest;

    // Block RAM with registered read port; the read register is pipeline stage 1
    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] ram_q;

    always_ff @(posedge clk) begin
        if (wr_accept && in_range) begin
            mem[mem_idx] <= writedata;
        end
        if (rd_accept) begin
            ram_q <= mem[mem_idx];
        end
    end

    logic [LATENCY-1:0] vld;
    logic               oor0;
    logic [WORD_W-1:0]  s0_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld  <= '0;
            oor0 <= 1'b0;
        end else begin
            vld[0] <= rd_accept;
            for (int k = 1; k < LATENCY; k++) begin
                vld[k] <= vld[k-1];
            end
            if (rd_accept) begin
                oor0 <= !in_range;
            end
        end
    end

    assign s0_data       = oor0 ? OOR_DATA : ram_q;
    assign readdatavalid = vld[LATENCY-1];

    generate
        if (LATENCY == 1) begin : g_lat1
            // ram_q is not reset, so mask it until the first read after reset
            logic have_data;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    have_data <= 1'b0;
                end else if (rd_accept) begin
                    have_data <= 1'b1;
                end
            end

            assign readdata = have_data ? s0_data : '0;
        end else begin : g_latn
            logic [WORD_W-1:0] sd [1:LATENCY-1];

            // Stages only move with a valid token, so the last stage holds between pulses
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 1; k < LATENCY; k++) begin
                        sd[k] <= '0;
                    end
                end else begin
                    if (vld[0]) begin
                        sd[1] <= s0_data;
                    end
                    for (int k = 2; k < LATENCY; k++) begin
                        if (vld[k-1]) begin
                            sd[k] <= sd[k-1];
                        end
                    end
                end
            end

            assign readdata = sd[LATENCY-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            case ({rd_accept, readdatavalid})
                2'b10:   pending <= pending + 1'b1;
                2'b01:   pending <= pending - 1'b1;
                default: pending <= pending;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if ((read && write) || (rd_accept && !in_range) || (wr_accept && !in_range)) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_avalon_sample_responder.sv
// Self-checking bench for avalon_sample_responder: directed scenarios plus a
// randomized run, all checked against a transaction-level reference model.
module tb_avalon_sample_responder;

    localparam int L      = 3;
    localparam int MAXP   = 4;
    localparam int DEPTH  = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic [3:0]  pending;
    logic        err;

    logic [23:0] address2 = '0;
    logic        read2 = 1'b0;
    logic        write2 = 1'b0;
    logic [31:0] writedata2 = '0;
    logic        waitrequest2;
    logic [31:0] readdata2;
    logic        readdatavalid2;
    logic [3:0]  pending2;
    logic        err2;

    avalon_sample_responder #(.ADDR_W(24), .DEPTH(DEPTH), .LATENCY(L), .MAX_PENDING(MAXP)) dut (
        .clk(clk), .reset(rst), .address(address), .read(read), .write(write),
        .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata),
        .readdatavalid(readdatavalid), .pending(pending), .err(err)
    );

    avalon_sample_responder #(.ADDR_W(24), .DEPTH(64), .LATENCY(3), .MAX_PENDING(2)) dut2 (
        .clk(clk), .reset(rst), .address(address2), .read(read2), .write(write2),
        .writedata(writedata2), .waitrequest(waitrequest2), .readdata(readdata2),
        .readdatavalid(readdatavalid2), .pending(pending2), .err(err2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] data; bit known; int due; } exp_t;
    typedef struct { logic [31:0] data; int at; } got_t;

    exp_t        exp_q[$];
    got_t        got_q[$];
    int          acc_q[$];
    logic [31:0] mem_m [int];
    bit          err_m = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    // Outstanding reads in cycle c: accepted before c and not yet retired
    function automatic int model_pending(int c);
        int n = 0;
        foreach (acc_q[i]) if (acc_q[i] + 1 <= c && c <= acc_q[i] + L) n++;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int   idx;
        bit   inr;
        bit   wexp;
        int   pm;
        exp_t e;
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            err_m = 1'b0;
        end else begin
            while (acc_q.size() > 0 && acc_q[0] + L < cyc) void'(acc_q.pop_front());
            pm = model_pending(cyc);
`ifdef AVALON_SAMPLE_RESPONDER_STALL_EN
            wexp = waitrequest || (pm == MAXP);
`else
            wexp = (pm == MAXP);
`endif
            idx = int'(address[23:2]);
            inr = idx < DEPTH;
            if (read && write) err_m = 1'b1;
            if (read && !wexp) begin
                e.known = !inr || mem_m.exists(idx);
                e.data  = !inr ? 32'hDEAD_BEEF : (mem_m.exists(idx) ? mem_m[idx] : 'x);
                e.due   = cyc + L;
                exp_q.push_back(e);
                acc_q.push_back(cyc);
                if (!inr) err_m = 1'b1;
            end else if (write && !read && !wexp) begin
                if (inr) mem_m[idx] = writedata;
                else     err_m = 1'b1;
            end
        end
    end

    always @(negedge clk) begin : mon
        int pm;
        got_t g;
        if (!rst) begin
            pm = model_pending(cyc);
            n_checks++;
            if (pending !== 4'(pm)) begin
                n_fail++;
                $display("FAIL mon_pending cyc=%0d got=%0d exp=%0d", cyc, pending, pm);
            end
            n_checks++;
`ifdef AVALON_SAMPLE_RESPONDER_STALL_EN
            if (pm == MAXP && waitrequest !== 1'b1) begin
`else
            if (waitrequest !== (pm == MAXP)) begin
`endif
                n_fail++;
                $display("FAIL mon_waitrequest cyc=%0d got=%b pending_model=%0d", cyc, waitrequest, pm);
            end
            n_checks++;
            if (err !== err_m) begin
                n_fail++;
                $display("FAIL mon_err cyc=%0d got=%b exp=%b", cyc, err, err_m);
            end
            n_checks++;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                if (readdatavalid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL mon_missing_rdv cyc=%0d got=%b exp=1", cyc, readdatavalid);
                end else if (exp_q[0].known && readdata !== exp_q[0].data) begin
                    n_fail++;
                    $display("FAIL mon_rdata cyc=%0d got=%h exp=%h", cyc, readdata, exp_q[0].data);
                end
                void'(exp_q.pop_front());
            end else if (readdatavalid !== 1'b0) begin
                n_fail++;
                $display("FAIL mon_unexpected_rdv cyc=%0d got=%b exp=0", cyc, readdatavalid);
            end
            if (readdatavalid === 1'b1) begin
                g.data = readdata;
                g.at   = cyc;
                got_q.push_back(g);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [23:0] a, input logic [31:0] d, output int waits);
        bit done = 1'b0;
        waits = 0;
        address = a; writedata = d; write = 1'b1; read = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            done = !waitrequest;
            if (!done) waits++;
            @(posedge clk); #1;
        end
        write = 1'b0;
    endtask

    task automatic do_read(input logic [23:0] a, output int acc, output int waits);
        bit done = 1'b0;
        waits = 0; acc = -1;
        address = a; read = 1'b1; write = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            done = !waitrequest;
            if (done) acc = cyc; else waits++;
            @(posedge clk); #1;
        end
        read = 1'b0;
    endtask

    task automatic wait_got(input int n, input int budget, output bit ok);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        ok = got_q.size() >= n;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        n_checks++;
        if (readdatavalid !== 1'b0 || readdata !== 32'h0 || pending !== 4'd0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values got rdv=%b rdata=%h pend=%0d err=%b exp 0/0/0/0",
                     readdatavalid, readdata, pending, err);
        end
        n_checks++;
        if (waitrequest !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_waitrequest got=%b exp=0", waitrequest);
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_write_readback();
        int acc[8];
        int w, wsum = 0;
        bit ok;
        for (int i = 0; i < 8; i++) begin
            do_write(24'(i * 4), 32'h1000 + 32'(i), w);
            wsum += w;
        end
        got_q.delete();
        for (int i = 0; i < 8; i++) begin
            do_read(24'(i * 4), acc[i], w);
            wsum += w;
        end
        wait_got(8, 50, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wr_rb_count got=%0d exp=8", got_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (got_q[i].data !== 32'h1000 + 32'(i) || got_q[i].at !== acc[i] + 3) begin
                    n_fail++;
                    $display("FAIL wr_rb_beat%0d got=%h@%0d exp=%h@%0d", i, got_q[i].data,
                             got_q[i].at, 32'h1000 + 32'(i), acc[i] + 3);
                end
            end
        end
`ifndef AVALON_SAMPLE_RESPONDER_STALL_EN
        n_checks++;
        if (wsum !== 0 || acc[7] !== acc[0] + 7) begin
            n_fail++;
            $display("FAIL wr_rb_no_wait got waits=%0d span=%0d exp 0/7", wsum, acc[7] - acc[0]);
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [31:0] got2[$];
        int  nacc = 0;
        int  seen_wait = 0;
        bit  acc, done;
        for (int i = 0; i < 6; i++) begin
            address2 = 24'(i * 4); writedata2 = 32'h2000 + 32'(i); write2 = 1'b1;
            done = 1'b0;
            for (int k = 0; k < 50 && !done; k++) begin
                @(negedge clk);
                done = !waitrequest2;
                @(posedge clk); #1;
            end
        end
        write2 = 1'b0;
        address2 = '0; read2 = 1'b1;
        for (int k = 0; k < 100 && got2.size() < 6; k++) begin
            @(negedge clk);
            n_checks++;
`ifdef AVALON_SAMPLE_RESPONDER_STALL_EN
            if (pending2 > 4'd2 || (pending2 == 4'd2 && waitrequest2 !== 1'b1)) begin
`else
            if (pending2 > 4'd2 || waitrequest2 !== (pending2 == 4'd2)) begin
`endif
                n_fail++;
                $display("FAIL bp_wait cyc=%0d got wait=%b pend=%0d exp wait=(pend==2)", cyc,
                         waitrequest2, pending2);
            end
            if (waitrequest2 === 1'b1 && pending2 == 4'd2) seen_wait++;
            if (readdatavalid2 === 1'b1) got2.push_back(readdata2);
            acc = read2 && !waitrequest2;
            @(posedge clk); #1;
            if (acc) begin
                nacc++;
                if (nacc == 6) read2 = 1'b0;
                else address2 = 24'(nacc * 4);
            end
        end
        read2 = 1'b0;
        n_checks++;
        if (got2.size() !== 6 || seen_wait == 0) begin
            n_fail++;
            $display("FAIL bp_count got=%0d full_cycles=%0d exp 6 and >0", got2.size(), seen_wait);
        end
        foreach (got2[i]) begin
            n_checks++;
            if (got2[i] !== 32'h2000 + 32'(i)) begin
                n_fail++;
                $display("FAIL bp_order%0d got=%h exp=%h", i, got2[i], 32'h2000 + 32'(i));
            end
        end
        idle(4);
        n_checks++;
        if (pending2 !== 4'd0) begin
            n_fail++;
            $display("FAIL bp_drain got=%0d exp=0", pending2);
        end
    endtask

    task automatic test_oor();
        int acc, w;
        bit ok;
        got_q.delete();
        do_read(24'(DEPTH * 4), acc, w);
        wait_got(1, 20, ok);
        n_checks++;
        if (!ok || got_q[0].data !== 32'hDEAD_BEEF || err !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_read got=%h err=%b exp=deadbeef err=1", ok ? got_q[0].data : 32'h0, err);
        end
        do_write(24'h0, 32'h55, w);
        got_q.delete();
        do_read(24'h0, acc, w);
        wait_got(1, 20, ok);
        n_checks++;
        if (!ok || got_q[0].data !== 32'h55 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_then_write got=%h err=%b exp=00000055 err=1", ok ? got_q[0].data : 32'h0, err);
        end
    endtask

    task automatic test_rw_conflict();
        int  acc, w;
        bit  ok, done;
        pulse_reset();
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL rw_pre_err got=%b exp=0", err);
        end
        do_write(24'd8, 32'h11, w);
        got_q.delete();
        address = 24'd8; writedata = 32'hAA; read = 1'b1; write = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            done = !waitrequest;
            @(posedge clk); #1;
        end
        read = 1'b0; write = 1'b0;
        wait_got(1, 20, ok);
        idle(5);
        n_checks++;
        if (!ok || got_q.size() !== 1 || got_q[0].data !== 32'h11 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL rw_conflict got n=%0d data=%h err=%b exp n=1 data=00000011 err=1",
                     got_q.size(), ok ? got_q[0].data : 32'h0, err);
        end
        got_q.delete();
        do_read(24'd8, acc, w);
        wait_got(1, 20, ok);
        n_checks++;
        if (!ok || got_q[0].data !== 32'h11) begin
            n_fail++;
            $display("FAIL rw_mem_kept got=%h exp=00000011", ok ? got_q[0].data : 32'h0);
        end
    endtask

    task automatic test_reset_inflight();
        int acc, w;
        got_q.delete();
        address = 24'd0; read = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_read(24'(i * 4), acc, w);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(10);
        n_checks++;
        if (got_q.size() !== 0 || readdatavalid !== 1'b0 || pending !== 4'd0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_inflight got n=%0d rdv=%b pend=%0d err=%b exp 0/0/0/0",
                     got_q.size(), readdatavalid, pending, err);
        end
    endtask

    task automatic test_random();
        int  w, nacc = 0, nwait = 0;
        int  ncyc = 1000;
        int  r;
        for (int i = 0; i < 16; i++) begin
            do_write(24'(i * 4), $urandom, w);
        end
        got_q.delete();
        for (int k = 0; k < ncyc; k++) begin
            r = int'($urandom_range(0, 99));
            read  = (r < 45) || (r >= 97);
            write = (r >= 45 && r < 70) || (r >= 97);
            address = ($urandom_range(0, 19) == 0) ? 24'(DEPTH * 4 + 4 * $urandom_range(0, 7))
                                                    : 24'(4 * $urandom_range(0, 15));
            writedata = $urandom;
            @(negedge clk);
            if (waitrequest === 1'b1) nwait++;
            if (read && !waitrequest) nacc++;
            @(posedge clk); #1;
        end
        read = 1'b0; write = 1'b0;
        idle(10);
        n_checks++;
        if (got_q.size() !== nacc || exp_q.size() !== 0 || pending !== 4'd0) begin
            n_fail++;
            $display("FAIL random_drain got resp=%0d left=%0d pend=%0d exp resp=%0d left=0 pend=0",
                     got_q.size(), exp_q.size(), pending, nacc);
        end
`ifdef AVALON_SAMPLE_RESPONDER_STALL_EN
        n_checks++;
        if (nwait * 100 < ncyc * 15 || nwait * 100 > ncyc * 35) begin
            n_fail++;
            $display("FAIL random_duty got=%0d/%0d exp about 25 percent", nwait, ncyc);
        end
`else
        n_checks++;
        if (nwait !== 0) begin
            n_fail++;
            $display("FAIL random_no_wait got=%0d exp=0", nwait);
        end
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d exp completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write_readback();
        test_backpressure();
        test_oor();
        test_rw_conflict();
        test_reset_inflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
